mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port memory controller between the single-cycle core's fetch/load-store interface and the shared word-addressed RAM. It accepts level-held instruction-fetch and data requests from the core, arbitrates them onto one RAM port with a fixed read latency, and returns fetched instructions and load data with one-cycle `i_ready` / `d_ready` pulses. It sits directly below the core top level and is the only master of the RAM.

## Interface
- `ADDR_W`, 10: RAM word-address width. RAM depth is 2^ADDR_W words.
- `RAM_LATENCY`, 2: cycles from the `ram_en` cycle to `ram_rdata` being valid, range 1..15.
- `clk` input 1: sole clock. All logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `i_read` input 1: instruction fetch request, held by the core until `i_ready`.
- `i_addr` input 32: fetch byte address.
- `i_ready` output 1: one-cycle pulse; `instruction_out` is valid.
- `instruction_out` output 32: last fetched word, held until the next fetch completes.
- `memRead` input 1: data load request, held until `d_ready`.
- `memWrite` input 1: data store request, held until `d_ready`.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store data.
- `d_ready` output 1: one-cycle pulse; load data is valid or the store is committed.
- `memload` output 32: last load data, held until the next load completes.
- `busy` output 1: high in every state except IDLE.
- `ram_en` output 1: RAM access strobe, one cycle per access.
- `ram_we` output 1: write enable, valid with `ram_en`.
- `ram_addr` output ADDR_W: word address.
- `ram_wdata` output 32: write data.
- `ram_rdata` input 32: read data, valid RAM_LATENCY cycles after the `ram_en` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Sample requests on each edge.
  - Priority: `memWrite` over `memRead` over `i_read`. If `memRead` and `memWrite` are both high, the access is a write only.
  - On selecting a request, latch the kind (IFETCH / LOAD / STORE), the address, and the store data, then go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE** (exactly one cycle)
  - `ram_en`=1, `ram_addr`=latched addr[ADDR_W+1:2], `ram_we`=1 for STORE only, `ram_wdata`=latched data.
  - STORE: go to RESP.
  - IFETCH / LOAD: go to WAIT and load the latency counter with 1.
- **WAIT**
  - Counter increments each cycle.
  - At the edge ending the cycle where counter == RAM_LATENCY, capture `ram_rdata` into `instruction_out` (IFETCH) or `memload` (LOAD), then go to RESP.
- **RESP** (exactly one cycle)
  - Pulse `i_ready` (IFETCH) or `d_ready` (LOAD/STORE), then go to IDLE.
  - Requests are not sampled in RESP. A request still high in the following IDLE cycle is treated as a new access; a continuous `i_read` therefore streams sequential fetches.
- **Address rules**
  - Address bits [1:0] are ignored; misaligned addresses are silently word-aligned.
  - Address bits above ADDR_W+1 are ignored, so addresses wrap modulo RAM depth.
- **Request withdrawal:** a request dropped after it leaves IDLE does not abort the access. The RAM cycle completes, the ready pulse still fires, and a store is still written.
- **Output registering**
  - `ram_*` outputs are registered.
  - `ram_en`/`ram_we` are 0 outside ISSUE.
  - `ram_addr`/`ram_wdata` hold their last values.
- **Reset**
  - `rst` high at an edge forces IDLE from any state, including mid-WAIT.
  - Reset clears the counter and zeroes every output: `i_ready`, `d_ready`, `busy`, `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `instruction_out`, `memload`.
  - A RAM response in flight at reset is discarded.

## Timing
- Cycle c0 is the first IDLE cycle in which the request is high.
- Read (IFETCH/LOAD): `ram_en` in c1, data captured at the end of c1+RAM_LATENCY, ready pulse in c2+RAM_LATENCY. At the default setting the ready pulse is in c4.
- Store: `ram_en`+`ram_we` in c1, `d_ready` in c2.
- Throughput: one access per RAM_LATENCY+3 cycles for reads and 3 cycles for stores.
- `busy` is high from c1 through the RESP cycle inclusive.
- Ready outputs are never high for more than one consecutive cycle. `i_ready` and `d_ready` are never high together.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `i_read`=1 -> all outputs 0, no `ram_en`. Release -> `ram_en` exactly one cycle later.
- **Fetch:** preload word 4 = 0x3E800093, `i_read`=1, `i_addr`=0x10 -> `ram_addr`=4 in c1, `i_ready` pulse in c4, `instruction_out`=0x3E800093 held afterwards.
- **Store then load:** `memWrite`, `d_addr`=0x20, `d_wdata`=0xDEADBEEF -> `ram_we` in c1, `d_ready` in c2. Then `memRead` at 0x23 -> `memload`=0xDEADBEEF, `d_ready` in c4.
- **Contention:** `i_read` and `memRead` rise in the same cycle -> the load is serviced first (`d_ready` in c4), then the fetch (`ram_en` in c6, `i_ready` in c9).
- **Wrap / both flags:** `memRead`=`memWrite`=1 at `d_addr`=0x1004 with ADDR_W=10 -> a write to word 1, no capture into `memload`.
- **Reset mid-WAIT:** assert `rst` in the c2 cycle of a fetch -> no `i_ready`, `instruction_out`=0, IDLE next cycle, a fresh fetch then completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates core fetch/load/store requests onto one fixed-latency RAM port
module mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic              i_ready,
  output logic [31:0]       instruction_out,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       memload,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {IFETCH, LOAD, STORE} kind_t;
  state_t state;
  kind_t kind, sel_kind;
  logic [3:0] cnt;
  logic req;
  logic [31:0] sel_addr;
  always_comb begin
    req = memWrite | memRead | i_read;
    sel_kind = memWrite ? STORE : memRead ? LOAD : IFETCH;
    sel_addr = (memWrite | memRead) ? d_addr : i_addr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kind <= IFETCH;
      cnt <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      busy <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      instruction_out <= '0;
      memload <= '0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: if (req) begin
          kind <= sel_kind;
          ram_en <= 1'b1;
          ram_we <= memWrite;
          ram_addr <= sel_addr[ADDR_W+1:2];
          ram_wdata <= d_wdata;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= 4'd1;
          d_ready <= kind == STORE;
          state <= kind == STORE ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'(RAM_LATENCY)) begin
          if (kind == IFETCH) instruction_out <= ram_rdata;
          else memload <= ram_rdata;
          i_ready <= kind == IFETCH;
          d_ready <= kind != IFETCH;
          state <= RESP;
        end else cnt <= cnt + 4'd1;
        RESP: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench with a cycle-schedule reference model and a bench-side RAM
module tb_mem_ctrl;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam logic [31:0] SENT = 32'hBAD0_0BAD;
  logic clk = 0, rst = 1;
  logic i_read = 0, memRead = 0, memWrite = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic i_ready, d_ready, busy, ram_en, ram_we;
  logic [31:0] instruction_out, memload, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  int checks = 0, errors = 0;
  logic [31:0] ram [1<<AW];
  logic [31:0] ref_mem [1<<AW];
  logic [31:0] pipe [RL];
  int t = 0, m_kind = 0, m_a = 0, last;
  logic [31:0] m_ins = 0, m_load = 0, m_wdata = 0, m_data = 0;
  logic [AW-1:0] m_addr = 0;

  mem_ctrl #(.ADDR_W(AW), .RAM_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready),
    .instruction_out(instruction_out), .memRead(memRead), .memWrite(memWrite),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .memload(memload),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = pipe[RL-1];
  always @(posedge clk) begin
    if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
    pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : SENT;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end

  // Schedule model: t counts cycles since the request was accepted (0 = idle);
  // kind 0 fetch, 1 load, 2 store; an access ends at t = 2 (store) or RL+2 (read).
  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_ins = 0; m_load = 0; m_addr = 0; m_wdata = 0;
    end else begin
      if (t == 0) begin
        if (memWrite || memRead || i_read) begin
          t = 1;
          m_kind = memWrite ? 2 : memRead ? 1 : 0;
          m_a = int'(((memWrite || memRead) ? d_addr : i_addr) / 4 % (1 << AW));
          m_addr = AW'(m_a);
          m_wdata = d_wdata;
          m_data = d_wdata;
        end
      end else if (t == last) t = 0;
      else t++;
      last = m_kind == 2 ? 2 : RL + 2;
      if (t != 0 && t == last) begin
        if (m_kind == 2) ref_mem[m_a] = m_data;
        else if (m_kind == 0) m_ins = ref_mem[m_a];
        else m_load = ref_mem[m_a];
      end
    end
    last = m_kind == 2 ? 2 : RL + 2;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(t != 0));
    check("ram_en", 32'(ram_en), 32'(t == 1));
    check("ram_we", 32'(ram_we), 32'(t == 1 && m_kind == 2));
    check("i_ready", 32'(i_ready), 32'(t != 0 && t == last && m_kind == 0));
    check("d_ready", 32'(d_ready), 32'(t != 0 && t == last && m_kind != 0));
    check("ram_addr", 32'(ram_addr), 32'(m_addr));
    check("ram_wdata", ram_wdata, m_wdata);
    check("instruction_out", instruction_out, m_ins);
    check("memload", memload, m_load);
  end

  task automatic run(input logic ir, input logic mr, input logic mw, input logic [31:0] ia,
                     input logic [31:0] da, input logic [31:0] wd,
                     output int en1, output int en2, output int irc, output int drc);
    bit wi, wdd;
    en1 = 0; en2 = 0; irc = 0; drc = 0;
    @(negedge clk);
    i_read = ir; memRead = mr; memWrite = mw; i_addr = ia; d_addr = da; d_wdata = wd;
    wi = ir; wdd = mr | mw;
    for (int k = 1; k <= 40 && (wi || wdd); k++) begin
      @(negedge clk);
      if (ram_en) begin
        if (en1 == 0) en1 = k;
        else if (en2 == 0) en2 = k;
      end
      if (i_ready) begin irc = k; i_read = 0; wi = 0; end
      if (d_ready) begin drc = k; memRead = 0; memWrite = 0; wdd = 0; end
    end
    if (wi || wdd) begin
      checks++; errors++;
      $display("FAIL timeout: ready never arrived within 40 cycles");
      i_read = 0; memRead = 0; memWrite = 0;
    end
  endtask

  initial begin
    int e1, e2, ic, dc;
    logic [31:0] w5;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h3E800093;
    ref_mem[4] = 32'h3E800093;
    w5 = 32'd5 * 32'h9E3779B9;
    for (int i = 0; i < RL; i++) pipe[i] = SENT;
    i_read = 1;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset ram_en", 32'(ram_en), 0);
    check("reset instruction_out", instruction_out, 0);
    rst = 0;
    @(negedge clk);
    check("ram_en after release", 32'(ram_en), 1);
    for (int k = 0; k < 20 && !i_ready; k++) @(negedge clk);
    check("i_ready after release", 32'(i_ready), 1);
    i_read = 0;

    run(1, 0, 0, 32'h10, 0, 0, e1, e2, ic, dc);
    check("fetch en cycle", 32'(e1), 1);
    check("fetch ready cycle", 32'(ic), 4);
    check("fetch ram_addr", 32'(ram_addr), 4);
    repeat (3) @(negedge clk);
    check("fetch held", instruction_out, 32'h3E800093);

    run(0, 0, 1, 0, 32'h20, 32'hDEADBEEF, e1, e2, ic, dc);
    check("store en cycle", 32'(e1), 1);
    check("store ready cycle", 32'(dc), 2);
    run(0, 1, 0, 0, 32'h23, 0, e1, e2, ic, dc);
    check("load ready cycle", 32'(dc), 4);
    check("load data", memload, 32'hDEADBEEF);

    run(1, 1, 0, 32'h14, 32'h20, 0, e1, e2, ic, dc);
    check("contention d_ready", 32'(dc), 4);
    check("contention fetch en", 32'(e2), 6);
    check("contention i_ready", 32'(ic), 9);
    check("contention fetch data", instruction_out, w5);

    run(0, 1, 1, 0, 32'h1004, 32'h12345678, e1, e2, ic, dc);
    check("wrap ready cycle", 32'(dc), 2);
    check("wrap ram_addr", 32'(ram_addr), 1);
    check("wrap ram word", ram[1], 32'h12345678);
    check("wrap no capture", memload, 32'hDEADBEEF);

    @(negedge clk);
    i_read = 1; i_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; i_read = 0;
    check("midwait busy", 32'(busy), 0);
    check("midwait instruction_out", instruction_out, 0);
    repeat (4) begin
      @(negedge clk);
      check("midwait no i_ready", 32'(i_ready), 0);
    end
    run(1, 0, 0, 32'h10, 0, 0, e1, e2, ic, dc);
    check("refetch ready cycle", 32'(ic), 4);
    check("refetch data", instruction_out, 32'h3E800093);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
